rs_age_multi: RTL

- Parametrised reservation station for the ALU path, placed between decoder/ROB issue logic and the ALU.
- Holds RS_SIZE entries. Captures operands from NUM_WB broadcast channels.
- Dispatches the oldest ready entry through a valid/ready output register, so the ALU can stall it.
- Adds over the previous RS: configurable depth and wakeup channel count, age-ordered selection, dispatch backpressure, and a free-entry count.

---
 rtl/rs_age_multi_if.sv | 48 ++++
 rtl/rs_age_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rs_age_multi_if.sv
// Issue, wakeup-broadcast and dispatch bundle for the age-ordered ALU reservation station.
// master = decoder/ROB/ALU side, slave = the reservation station.
interface rs_age_multi_if #(
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4,
    parameter int NUM_WB    = 2
);
    logic                          issue_valid;
    logic [4:0]                    issue_op;
    logic [ROB_WIDTH-1:0]          issue_rob_id;
    logic [31:0]                   issue_tja;
    logic [31:0]                   issue_fja;
    logic                          has_dep_j;
    logic                          has_dep_k;
    logic [ROB_WIDTH-1:0]          dep_j;
    logic [ROB_WIDTH-1:0]          dep_k;
    logic [31:0]                   val_j;
    logic [31:0]                   val_k;
    logic [NUM_WB-1:0]             wb_valid;
    logic [NUM_WB*ROB_WIDTH-1:0]   wb_rob_id;
    logic [NUM_WB*32-1:0]          wb_value;
    logic                          rs_full;
    logic [RS_WIDTH:0]             free_count;
    logic                          out_valid;
    logic                          out_ready;
    logic [4:0]                    out_op;
    logic [31:0]                   out_lhs;
    logic [31:0]                   out_rhs;
    logic [ROB_WIDTH-1:0]          out_rob_id;
    logic [31:0]                   out_tja;
    logic [31:0]                   out_fja;

    modport master (
        output issue_valid, issue_op, issue_rob_id, issue_tja, issue_fja,
               has_dep_j, has_dep_k, dep_j, dep_k, val_j, val_k,
               wb_valid, wb_rob_id, wb_value, out_ready,
        input  rs_full, free_count, out_valid, out_op, out_lhs, out_rhs,
               out_rob_id, out_tja, out_fja
    );

    modport slave (
        input  issue_valid, issue_op, issue_rob_id, issue_tja, issue_fja,
               has_dep_j, has_dep_k, dep_j, dep_k, val_j, val_k,
               wb_valid, wb_rob_id, wb_value, out_ready,
        output rs_full, free_count, out_valid, out_op, out_lhs, out_rhs,
               out_rob_id, out_tja, out_fja
    );
endinterface

// File: rtl/rs_age_multi.sv
// ALU reservation station: multi-channel operand wakeup, oldest-ready selection via an
// age matrix, and a valid/ready output register the ALU can stall.
module rs_age_multi #(
    parameter int RS_SIZE   = 8,
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = 4,
    parameter int NUM_WB    = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear,
    rs_age_multi_if.slave bus
);
    localparam int CW = RS_WIDTH + 1;

    typedef struct packed {
        logic [4:0]           op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic                 dj;
        logic                 dk;
        logic [ROB_WIDTH-1:0] qj;
        logic [ROB_WIDTH-1:0] qk;
        logic [ROB_WIDTH-1:0] rob;
        logic [31:0]          tja;
        logic [31:0]          fja;
    } ent_t;

    typedef struct packed {
        logic [4:0]           op;
        logic [31:0]          lhs;
        logic [31:0]          rhs;
        logic [ROB_WIDTH-1:0] rob;
        logic [31:0]          tja;
        logic [31:0]          fja;
    } out_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } wb_t;

    logic [RS_SIZE-1:0]              busy_q, busy_d;
    ent_t                            ent_q [RS_SIZE];
    ent_t                            ent_d [RS_SIZE];
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
    out_t                            out_q, out_d;
    logic                            out_valid_q, out_valid_d;

    logic [RS_SIZE-1:0]  ready, sel_oh;
    logic [RS_WIDTH-1:0] sel_idx, free_idx;
    logic                any_ready, full;
    logic [CW-1:0]       free_cnt;
    wb_t                 wake_j [RS_SIZE];
    wb_t                 wake_k [RS_SIZE];
    wb_t                 iss_j, iss_k;
    ent_t                new_ent;

    // Lowest channel index wins when several broadcast the same tag.
    function automatic wb_t wb_lookup(input logic [ROB_WIDTH-1:0]        tag,
                                      input logic [NUM_WB-1:0]           vld,
                                      input logic [NUM_WB*ROB_WIDTH-1:0] ids,
                                      input logic [NUM_WB*32-1:0]        vals);
        wb_t r;
        r = '0;
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (vld[c] && ids[c*ROB_WIDTH +: ROB_WIDTH] == tag) begin
                r.hit = 1'b1;
                r.val = vals[c*32 +: 32];
            end
        end
        return r;
    endfunction

    always_comb begin
        free_cnt = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_cnt = free_cnt + CW'(!busy_q[i]);
            if (!busy_q[i]) free_idx = RS_WIDTH'(i);
        end
        full = &busy_q;
    end

    // Oldest ready entry: no other ready entry is older than it.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i]  = busy_q[i] && !ent_q[i].dj && !ent_q[i].dk;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            sel_oh[i] = ready[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
            if (sel_oh[i]) sel_idx = RS_WIDTH'(i);
        end
        any_ready = |ready;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j[i] = wb_lookup(ent_q[i].qj, bus.wb_valid, bus.wb_rob_id, bus.wb_value);
            wake_k[i] = wb_lookup(ent_q[i].qk, bus.wb_valid, bus.wb_rob_id, bus.wb_value);
        end
        iss_j = wb_lookup(bus.dep_j, bus.wb_valid, bus.wb_rob_id, bus.wb_value);
        iss_k = wb_lookup(bus.dep_k, bus.wb_valid, bus.wb_rob_id, bus.wb_value);

        new_ent     = '0;
        new_ent.op  = bus.issue_op;
        new_ent.rob = bus.issue_rob_id;
        new_ent.tja = bus.issue_tja;
        new_ent.fja = bus.issue_fja;
        new_ent.qj  = bus.dep_j;
        new_ent.qk  = bus.dep_k;
        new_ent.dj  = bus.has_dep_j && !iss_j.hit;
        new_ent.dk  = bus.has_dep_k && !iss_k.hit;
        new_ent.vj  = !bus.has_dep_j ? bus.val_j : (iss_j.hit ? iss_j.val : 32'd0);
        new_ent.vk  = !bus.has_dep_k ? bus.val_k : (iss_k.hit ? iss_k.val : 32'd0);
    end

    always_comb begin
        busy_d      = busy_q;
        ent_d       = ent_q;
        older_d     = older_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && ent_q[i].dj && wake_j[i].hit) begin
                    ent_d[i].vj = wake_j[i].val;
                    ent_d[i].dj = 1'b0;
                end
                if (busy_q[i] && ent_q[i].dk && wake_k[i].hit) begin
                    ent_d[i].vk = wake_k[i].val;
                    ent_d[i].dk = 1'b0;
                end
            end
            if (!out_valid_q || bus.out_ready) begin
                if (any_ready) begin
                    out_d.op        = ent_q[sel_idx].op;
                    out_d.lhs       = ent_q[sel_idx].vj;
                    out_d.rhs       = ent_q[sel_idx].vk;
                    out_d.rob       = ent_q[sel_idx].rob;
                    out_d.tja       = ent_q[sel_idx].tja;
                    out_d.fja       = ent_q[sel_idx].fja;
                    out_valid_d     = 1'b1;
                    busy_d[sel_idx] = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // free_idx comes from start-of-cycle busy bits, so it never collides with the dispatched slot.
            if (bus.issue_valid && !full) begin
                busy_d[free_idx] = 1'b1;
                ent_d[free_idx]  = new_ent;
                for (int k = 0; k < RS_SIZE; k++) begin
                    older_d[k][free_idx] = (k != int'(free_idx));
                    older_d[free_idx][k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            older_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
        end else if (rdy_in) begin
            busy_q      <= busy_d;
            older_q     <= older_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ent_q       <= ent_d;
        end
    end

    assign bus.rs_full    = full;
    assign bus.free_count = free_cnt;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_op     = out_q.op;
    assign bus.out_lhs    = out_q.lhs;
    assign bus.out_rhs    = out_q.rhs;
    assign bus.out_rob_id = out_q.rob;
    assign bus.out_tja    = out_q.tja;
    assign bus.out_fja    = out_q.fja;
endmodule
